fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  downstream (decode) stall; pipeline outputs SHALL hold while high.
REQ-005 flush  in  1  redirect request; discards in-flight fetch, restarts at redirect_pc.
REQ-006 redirect_pc  in  [`ADDR_SIZE:0]  new PC, sampled only when flush=1.
REQ-007 imem_req_valid  out  1  instruction memory request valid.
REQ-008 imem_req_ready  in  1  memory accepts request when high together with imem_req_valid.
REQ-009 imem_addr  out  [`ADDR_SIZE:0]  request word address.
REQ-010 imem_resp_valid  in  1  one-cycle response strobe, at least 1 cycle after acceptance.
REQ-011 imem_rdata  in  [`INSTR_SIZE:0]  instruction word, valid with imem_resp_valid.
REQ-012 imem_resp_err  in  1  access fault, valid with imem_resp_valid.
REQ-013 PC_out  out  [`ADDR_SIZE:0]  PC of presented instruction.
REQ-014 instr_out  out  [`INSTR_SIZE:0]  presented instruction word.
REQ-015 exception_out  out  [`EX_WIDTH:0]  exception code for presented slot.
REQ-016 exception_out_valid  out  1  exception_out meaningful.
REQ-017 pipeline_out_valid  out  1  slot valid to decode.

Function
REQ-018 States SHALL be REQ, WAIT, HOLD, HALT, plus a drop flag; at most one request outstanding.
REQ-019 REQ: imem_req_valid=1, imem_addr=pc; on ready -> WAIT; addr stable until accepted except on flush.
REQ-020 WAIT: on resp (drop=0, stall=0) outputs load {pc, rdata}, pipeline_out_valid<=1, pc<=pc+4 (mod 2^32), -> REQ.
REQ-021 WAIT: resp while stall=1 SHALL capture {pc, rdata, err} in 1-entry hold buffer -> HOLD; no request issued in HOLD.
REQ-022 HOLD: when stall drops, buffer loads outputs next edge, pc<=pc+4, -> REQ.
REQ-023 Any non-stall cycle with no new slot SHALL set pipeline_out_valid<=0; each slot valid for exactly one unstalled cycle.
REQ-024 stall=1 (no flush) SHALL hold PC_out, instr_out, exception_out, exception_out_valid, pipeline_out_valid.
REQ-025 flush SHALL win over stall and resp: pipeline_out_valid<=0, pc<=redirect_pc, hold buffer cleared.
REQ-026 flush in WAIT without same-cycle resp SHALL set drop; next resp discarded, drop cleared, -> REQ.
REQ-027 flush in REQ/HOLD/HALT, or WAIT with same-cycle resp, SHALL -> REQ with imem_addr=redirect_pc next cycle.
REQ-028 redirect_pc[1:0]!=0 SHALL issue no request; emit slot with exception_out=`EX_INSTR_MISALIGNED, exception_out_valid=1, PC_out=redirect_pc, instr_out=`NOP_INSTR, -> HALT.
REQ-029 imem_resp_err=1 SHALL emit slot with exception_out=`EX_INSTR_ACCESS_FAULT, exception_out_valid=1, -> HALT; pc not incremented.
REQ-030 HALT SHALL issue no requests until flush.

Reset
REQ-031 During reset: imem_req_valid=0, pc=RESET_VECTOR, drop=0, buffer empty, PC_out=0, instr_out=`NOP_INSTR (32'h0000_0013), exception_out=0, exception_out_valid=0, pipeline_out_valid=0.
REQ-032 First cycle after reset deasserts SHALL be REQ with imem_addr=RESET_VECTOR.
REQ-033 Reset mid-WAIT SHALL abandon the request without drop; memory shares the same reset.

Structure
REQ-034 `EX_INSTR_MISALIGNED, `EX_INSTR_ACCESS_FAULT, `NOP_INSTR, state encodings SHALL live in def_params.v.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Reset release, 1-cycle memory returning 0x00500093 -> req addr 0x0, slot PC_out=0x0, instr_out=0x00500093, next req addr 0x4.
REQ-037 imem_req_ready low 3 cycles -> imem_addr stable 0x4 throughout, single acceptance.
REQ-038 stall=1 two cycles while resp 0x00A00113 at PC 0x8 arrives -> outputs unchanged; slot PC 0x8 valid one cycle after stall drops, next req 0xC.
REQ-039 flush, redirect_pc=0x100, during WAIT -> stale resp dropped, next req 0x100, no slot for stale word.
REQ-040 flush with redirect_pc=0x102 -> no request; slot exception `EX_INSTR_MISALIGNED, PC_out=0x102; HALT until next flush.
REQ-041 imem_resp_err=1 at PC 0x20 -> slot exception `EX_INSTR_ACCESS_FAULT, PC_out=0x20; no further requests.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, exception codes, state encodings and slot/buffer types for the fetch stage.
package fetch_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;
    localparam int EX_WIDTH   = 3;

    localparam logic [INSTR_SIZE:0] NOP_INSTR             = 32'h0000_0013;
    localparam logic [EX_WIDTH:0]   EX_INSTR_MISALIGNED   = 4'd0;
    localparam logic [EX_WIDTH:0]   EX_INSTR_ACCESS_FAULT = 4'd1;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // One decode slot as presented on the pipeline outputs.
    typedef struct packed {
        logic [ADDR_SIZE:0]  pc;
        logic [INSTR_SIZE:0] instr;
        logic [EX_WIDTH:0]   exc;
        logic                exc_valid;
        logic                valid;
    } slot_t;

    // Response parked while decode is stalled.
    typedef struct packed {
        logic                valid;
        logic [ADDR_SIZE:0]  pc;
        logic [INSTR_SIZE:0] instr;
        logic                err;
    } hbuf_t;

    localparam slot_t SLOT_RESET = '{pc: '0, instr: NOP_INSTR, exc: '0, exc_valid: 1'b0, valid: 1'b0};

    function automatic logic [ADDR_SIZE:0] next_pc(input logic [ADDR_SIZE:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch.sv
// Single-outstanding instruction fetch stage with a one-entry stall buffer,
// redirect handling (drop of stale responses) and halting on fetch exceptions.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_SIZE:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_SIZE:0]    redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_SIZE:0]    imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [INSTR_SIZE:0]   imem_rdata,
    input  logic                  imem_resp_err,
    output logic [ADDR_SIZE:0]    PC_out,
    output logic [INSTR_SIZE:0]   instr_out,
    output logic [EX_WIDTH:0]     exception_out,
    output logic                  exception_out_valid,
    output logic                  pipeline_out_valid
);

    logic [1:0]         state_q, state_d;
    logic [ADDR_SIZE:0] pc_q, pc_d;
    logic               drop_q, drop_d;
    hbuf_t              hbuf_q, hbuf_d;
    slot_t              slot_q, slot_d;
    logic               pc_misaligned;
    logic               accept;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // Flush masks the request so memory never accepts an address being redirected away from.
    assign imem_req_valid = !reset && !flush && (state_q == ST_REQ) && !pc_misaligned;
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign PC_out              = slot_q.pc;
    assign instr_out           = slot_q.instr;
    assign exception_out       = slot_q.exc;
    assign exception_out_valid = slot_q.exc_valid;
    assign pipeline_out_valid  = slot_q.valid;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        hbuf_d  = hbuf_q;
        slot_d  = slot_q;

        if (flush) begin
            slot_d.valid = 1'b0;
            pc_d         = redirect_pc;
            hbuf_d       = '0;
            if (state_q == ST_WAIT && !imem_resp_valid) begin
                drop_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            if (!stall) begin
                slot_d.valid = 1'b0;
            end
            case (state_q)
                ST_REQ: begin
                    if (pc_misaligned) begin
                        if (!stall) begin
                            slot_d  = '{pc: pc_q, instr: NOP_INSTR, exc: EX_INSTR_MISALIGNED,
                                        exc_valid: 1'b1, valid: 1'b1};
                            state_d = ST_HALT;
                        end
                    end else if (accept) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (stall) begin
                            hbuf_d  = '{valid: 1'b1, pc: pc_q, instr: imem_rdata, err: imem_resp_err};
                            state_d = ST_HOLD;
                        end else if (imem_resp_err) begin
                            slot_d  = '{pc: pc_q, instr: NOP_INSTR, exc: EX_INSTR_ACCESS_FAULT,
                                        exc_valid: 1'b1, valid: 1'b1};
                            state_d = ST_HALT;
                        end else begin
                            slot_d  = '{pc: pc_q, instr: imem_rdata, exc: '0,
                                        exc_valid: 1'b0, valid: 1'b1};
                            pc_d    = next_pc(pc_q);
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall && hbuf_q.valid) begin
                        hbuf_d.valid = 1'b0;
                        if (hbuf_q.err) begin
                            slot_d  = '{pc: hbuf_q.pc, instr: NOP_INSTR, exc: EX_INSTR_ACCESS_FAULT,
                                        exc_valid: 1'b1, valid: 1'b1};
                            state_d = ST_HALT;
                        end else begin
                            slot_d  = '{pc: hbuf_q.pc, instr: hbuf_q.instr, exc: '0,
                                        exc_valid: 1'b0, valid: 1'b1};
                            pc_d    = next_pc(hbuf_q.pc);
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the combinational block above computes every _d.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_VECTOR;
            drop_q  <= 1'b0;
            hbuf_q  <= '0;
            slot_q  <= SLOT_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            hbuf_q  <= hbuf_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage with a small latency-programmable memory model.
module tb_fetch;
    import fetch_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                stall = 1'b0;
    logic                flush = 1'b0;
    logic [ADDR_SIZE:0]  redirect_pc = '0;
    logic                imem_req_valid;
    logic                imem_req_ready = 1'b1;
    logic [ADDR_SIZE:0]  imem_addr;
    logic                imem_resp_valid = 1'b0;
    logic [INSTR_SIZE:0] imem_rdata = '0;
    logic                imem_resp_err = 1'b0;
    logic [ADDR_SIZE:0]  PC_out;
    logic [INSTR_SIZE:0] instr_out;
    logic [EX_WIDTH:0]   exception_out;
    logic                exception_out_valid;
    logic                pipeline_out_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    int               mem_lat = 1;
    bit               err_en = 1'b0;
    logic [31:0]      err_addr = '0;
    bit               pend = 1'b0;
    logic [31:0]      pend_addr = '0;
    int               cnt = 0;
    logic [31:0]      acc_q[$];
    logic [31:0]      slot_log[$];

    fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata), .imem_resp_err(imem_resp_err),
        .PC_out(PC_out), .instr_out(instr_out), .exception_out(exception_out),
        .exception_out_valid(exception_out_valid), .pipeline_out_valid(pipeline_out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h00A0_0113;
            default: return 32'hDEAD_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Memory: acceptance seen mid-cycle, response strobe mem_lat cycles later.
    always @(negedge clk) begin
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_rdata      = mem_word(pend_addr);
                    imem_resp_err   = err_en && (pend_addr == err_addr);
                    pend            = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                cnt       = mem_lat;
                acc_q.push_back(imem_addr);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset && pipeline_out_valid && !stall) slot_log.push_back(PC_out);
    end

    task automatic restart(input logic [31:0] addr);
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; stall = 1'b0; imem_req_ready = 1'b0;
        err_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; flush = 1'b1; redirect_pc = addr;
        @(negedge clk);
        flush = 1'b0;
        #3;
        acc_q.delete();
        slot_log.delete();
    endtask

    task automatic wait_slot(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (pipeline_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #3;
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        tests_run++; if (PC_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_out: got %h want 0", PC_out); end
        tests_run++; if (instr_out !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000013", instr_out); end
        tests_run++; if ({exception_out, exception_out_valid, pipeline_out_valid} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_exc_valid: got %h/%b/%b want 0/0/0", exception_out, exception_out_valid, pipeline_out_valid); end
        @(negedge clk);
        reset = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_addr); end
    endtask

    task automatic test_basic;
        bit ok;
        wait_slot(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_timeout: got no slot want slot"); end
        tests_run++; if (PC_out !== 32'h0 || instr_out !== 32'h0050_0093) begin
            tests_failed++; $display("FAIL basic_slot: got pc=%h i=%h want pc=0 i=00500093", PC_out, instr_out); end
        tests_run++; if (acc_q.size() != 2 || acc_q[1] !== 32'h4) begin
            tests_failed++; $display("FAIL basic_next_req: got n=%0d want n=2 addr 4", acc_q.size()); end
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_one_cycle: got %b want 0", pipeline_out_valid); end
    endtask

    task automatic test_ready_low;
        bit ok;
        restart(32'h4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || acc_q.size() != 0) begin
                tests_failed++; $display("FAIL ready_low_hold: got v=%b a=%h n=%0d want v=1 a=4 n=0", imem_req_valid, imem_addr, acc_q.size()); end
        end
        @(negedge clk);
        imem_req_ready = 1'b1;
        #3;
        tests_run++; if (acc_q.size() != 1 || acc_q[0] !== 32'h4) begin
            tests_failed++; $display("FAIL ready_low_accept: got n=%0d want n=1 addr 4", acc_q.size()); end
        @(negedge clk);
        #3;
        tests_run++; if (acc_q.size() != 1 || imem_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ready_low_single: got n=%0d v=%b want n=1 v=0", acc_q.size(), imem_req_valid); end
        wait_slot(ok);
        tests_run++; if (!ok || PC_out !== 32'h4 || instr_out !== 32'h0010_0113) begin
            tests_failed++; $display("FAIL ready_low_slot: got pc=%h i=%h want pc=4 i=00100113", PC_out, instr_out); end
    endtask

    task automatic test_stall_resp;
        restart(32'h8);
        @(negedge clk);
        stall = 1'b1; imem_req_ready = 1'b1;
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b0 || PC_out !== 32'h0 || instr_out !== NOP_INSTR) begin
            tests_failed++; $display("FAIL stall_unchanged: got v=%b pc=%h i=%h want v=0 pc=0 i=00000013", pipeline_out_valid, PC_out, instr_out); end
        @(negedge clk);
        stall = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b0 || pipeline_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL stall_hold_state: got req=%b v=%b want req=0 v=0", imem_req_valid, pipeline_out_valid); end
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b1 || PC_out !== 32'h8 || instr_out !== 32'h00A0_0113) begin
            tests_failed++; $display("FAIL stall_release_slot: got v=%b pc=%h i=%h want v=1 pc=8 i=00a00113", pipeline_out_valid, PC_out, instr_out); end
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
            tests_failed++; $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=c", imem_req_valid, imem_addr); end
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_one_cycle: got %b want 0", pipeline_out_valid); end
    endtask

    task automatic test_stall_slot;
        bit ok;
        restart(32'h0);
        @(negedge clk);
        imem_req_ready = 1'b1;
        wait_slot(ok);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #3;
            tests_run++; if (!ok || pipeline_out_valid !== 1'b1 || PC_out !== 32'h0 || instr_out !== 32'h0050_0093) begin
                tests_failed++; $display("FAIL stall_slot_hold: got v=%b pc=%h i=%h want v=1 pc=0 i=00500093", pipeline_out_valid, PC_out, instr_out); end
        end
        stall = 1'b0;
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b1 || PC_out !== 32'h4 || instr_out !== 32'h0010_0113) begin
            tests_failed++; $display("FAIL stall_slot_next: got v=%b pc=%h i=%h want v=1 pc=4 i=00100113", pipeline_out_valid, PC_out, instr_out); end
    endtask

    task automatic test_flush_drop;
        bit ok;
        restart(32'h0);
        mem_lat = 3;
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop_wait: got req=%b want 0", imem_req_valid); end
        @(negedge clk);
        @(negedge clk);
        #3;
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || pipeline_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL flush_drop_req: got v=%b a=%h slot=%b want v=1 a=100 slot=0", imem_req_valid, imem_addr, pipeline_out_valid); end
        wait_slot(ok);
        tests_run++; if (!ok || PC_out !== 32'h100 || instr_out !== mem_word(32'h100) || slot_log.size() != 1) begin
            tests_failed++; $display("FAIL flush_drop_slot: got pc=%h i=%h n=%0d want pc=100 i=%h n=1", PC_out, instr_out, slot_log.size(), mem_word(32'h100)); end
        mem_lat = 1;
    endtask

    task automatic test_flush_same_resp;
        bit ok;
        restart(32'h0);
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || pipeline_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL flush_resp_req: got v=%b a=%h slot=%b want v=1 a=200 slot=0", imem_req_valid, imem_addr, pipeline_out_valid); end
        wait_slot(ok);
        tests_run++; if (!ok || PC_out !== 32'h200 || slot_log.size() != 1) begin
            tests_failed++; $display("FAIL flush_resp_slot: got pc=%h n=%0d want pc=200 n=1", PC_out, slot_log.size()); end
    endtask

    task automatic test_misaligned;
        restart(32'h10);
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        flush = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b0 || pipeline_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_no_req: got req=%b v=%b want 0/0", imem_req_valid, pipeline_out_valid); end
        @(negedge clk);
        imem_req_ready = 1'b1;
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b1 || PC_out !== 32'h102 || instr_out !== NOP_INSTR ||
                         exception_out !== EX_INSTR_MISALIGNED || exception_out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL misalign_slot: got v=%b pc=%h i=%h ex=%h/%b want v=1 pc=102 i=00000013 ex=%h/1",
                                     pipeline_out_valid, PC_out, instr_out, exception_out, exception_out_valid, EX_INSTR_MISALIGNED); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            tests_run++; if (imem_req_valid !== 1'b0 || pipeline_out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL misalign_halt: got req=%b v=%b want 0/0", imem_req_valid, pipeline_out_valid); end
        end
        tests_run++; if (acc_q.size() != 0) begin tests_failed++; $display("FAIL misalign_acc: got %0d want 0", acc_q.size()); end
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        flush = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
            tests_failed++; $display("FAIL misalign_exit: got v=%b a=%h want v=1 a=300", imem_req_valid, imem_addr); end
    endtask

    task automatic test_access_fault;
        restart(32'h20);
        @(negedge clk);
        imem_req_ready = 1'b1; err_en = 1'b1; err_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        #3;
        tests_run++; if (pipeline_out_valid !== 1'b1 || PC_out !== 32'h20 ||
                         exception_out !== EX_INSTR_ACCESS_FAULT || exception_out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL fault_slot: got v=%b pc=%h ex=%h/%b want v=1 pc=20 ex=%h/1",
                                     pipeline_out_valid, PC_out, exception_out, exception_out_valid, EX_INSTR_ACCESS_FAULT); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL fault_halt: got req=%b want 0", imem_req_valid); end
        end
        tests_run++; if (acc_q.size() != 1) begin tests_failed++; $display("FAIL fault_acc: got %0d want 1", acc_q.size()); end
        err_en = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        restart(32'h0);
        mem_lat = 3;
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #3;
        tests_run++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++; $display("FAIL reset_wait_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_addr); end
        wait_slot(ok);
        tests_run++; if (!ok || PC_out !== 32'h0 || instr_out !== 32'h0050_0093) begin
            tests_failed++; $display("FAIL reset_wait_slot: got pc=%h i=%h want pc=0 i=00500093", PC_out, instr_out); end
        mem_lat = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_low();
        test_stall_resp();
        test_stall_slot();
        test_flush_drop();
        test_flush_same_resp();
        test_misaligned();
        test_access_fault();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
